// File: rtl/clock_edge_monitor_pkg.sv
// Shared types and default constants for the forwarded-clock edge monitor.
package clock_edge_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_e;

  localparam int CNT_WIDTH_DEFAULT = 16;
  localparam int TIMEOUT_DEFAULT   = 1024;

endpackage

// File: rtl/clock_edge_monitor_sync.sv
// Resynchronises a foreign clock seen as data and emits registered one-cycle
// rise/fall pulses from the synchronised level and a one-cycle history flop.
module clock_sync
  import clock_edge_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic clk_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clock_edge_monitor.sv
// Observes a forwarded clock: edge pulses, period measurement in CLK cycles
// delivered over valid/ready, and a loss-of-clock timeout.
module clock_edge_monitor
  import clock_edge_monitor_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 enable,
  input  logic                 clk_in,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  input  logic                 period_ready,
  output logic                 overrun,
  output logic                 lost,
  output state_e               dbg_state
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   sync_rise, sync_fall;
  logic                   capture;
  logic                   xfer;

  clock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .clk_in (clk_in),
    .rise   (sync_rise),
    .fall   (sync_fall)
  );

  // Handshake: a transfer happens in any cycle with period_valid & period_ready.
  // period holds its value while valid and no new capture arrives; a capture
  // with a transfer in the same cycle keeps valid high; a capture onto an
  // untaken value overwrites it and pulses overrun.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    overrun_d      = 1'b0;
    capture        = 1'b0;
    xfer           = period_valid_q & period_ready;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync_rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      MEASURE: begin
        // A rise in the timeout cycle still counts as a valid measurement.
        if (sync_rise) begin
          capture  = 1'b1;
          period_d = cnt_q;
          cnt_d    = CNT_ONE;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = LOST;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOST: begin
        if (sync_rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    overrun_d      = capture & period_valid_q & ~period_ready;
    period_valid_d = capture | (period_valid_q & ~xfer);

    if (!enable) begin
      state_d        = IDLE;
      cnt_d          = '0;
      period_d       = period_q;
      period_valid_d = 1'b0;
      overrun_d      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign rise         = sync_rise;
  assign fall         = sync_fall;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign overrun      = overrun_q;
  assign lost         = (state_q == LOST);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Bench for clock_edge_monitor: two configurations share stimulus and are
// compared every cycle with a timestamp-based model, plus directed sequences.
module tb_clock_edge_monitor;
  import clock_edge_monitor_pkg::*;

  localparam int SYNC = 2;
  localparam int W_A  = 16;
  localparam int TO_A = 32;
  localparam int W_B  = 4;
  localparam int TO_B = 15;
  localparam int K    = 5;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic enable = 1'b0;
  logic clk_in = 1'b0;
  logic period_ready = 1'b0;

  always #5 CLK = ~CLK;

  logic           rise_a, fall_a, period_valid_a, overrun_a, lost_a;
  logic [W_A-1:0] period_a;
  state_e         state_a;
  logic           rise_b, fall_b, period_valid_b, overrun_b, lost_b;
  logic [W_B-1:0] period_b;
  state_e         state_b;

  clock_edge_monitor #(.CNT_WIDTH(W_A), .TIMEOUT(TO_A), .SYNC_STAGES(SYNC)) dut_a (
    .CLK(CLK), .RESETN(RESETN), .enable(enable), .clk_in(clk_in),
    .rise(rise_a), .fall(fall_a), .period(period_a), .period_valid(period_valid_a),
    .period_ready(period_ready), .overrun(overrun_a), .lost(lost_a), .dbg_state(state_a)
  );

  clock_edge_monitor #(.CNT_WIDTH(W_B), .TIMEOUT(TO_B), .SYNC_STAGES(SYNC)) dut_b (
    .CLK(CLK), .RESETN(RESETN), .enable(enable), .clk_in(clk_in),
    .rise(rise_b), .fall(fall_b), .period(period_b), .period_valid(period_valid_b),
    .period_ready(period_ready), .overrun(overrun_b), .lost(lost_b), .dbg_state(state_b)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Edge detection from the sampled history of clk_in; the period is the
  // distance between timestamps of successive rise pulses.
  int   cyc = 0;
  logic samp_q[$];
  bit   m_rise, m_fall;
  bit   m_run[2], m_lost[2], m_valid[2], m_ovr[2];
  int   m_start[2], m_period[2];

  function automatic int to_of(input int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  function automatic int max_of(input int i);
    return (i == 0) ? ((1 << W_A) - 1) : ((1 << W_B) - 1);
  endfunction

  task automatic model_step();
    bit r_old;
    bit cap;
    int el;
    int newp;
    cyc++;
    r_old = m_rise;
    for (int i = 0; i < 2; i++) begin
      cap  = 1'b0;
      newp = 0;
      if (!RESETN) begin
        m_run[i] = 0; m_lost[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_period[i] = 0;
      end else if (!enable) begin
        m_run[i] = 0; m_lost[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
      end else begin
        if (m_run[i]) begin
          el = cyc - m_start[i];
          if (el > max_of(i)) el = max_of(i);
          if (r_old) begin
            cap = 1'b1; newp = el; m_start[i] = cyc;
          end else if (el == to_of(i)) begin
            m_run[i] = 0; m_lost[i] = 1;
          end
        end else if (r_old) begin
          m_run[i] = 1; m_lost[i] = 0; m_start[i] = cyc;
        end
        m_ovr[i] = cap && m_valid[i] && !period_ready;
        if (cap) begin
          m_period[i] = newp; m_valid[i] = 1;
        end else if (m_valid[i] && period_ready) begin
          m_valid[i] = 0;
        end
      end
    end
    if (!RESETN) begin
      samp_q.delete();
      for (int k = 0; k < SYNC + 2; k++) samp_q.push_back(1'b0);
      m_rise = 0;
      m_fall = 0;
    end else begin
      samp_q.push_front(clk_in);
      void'(samp_q.pop_back());
      m_rise = samp_q[SYNC] & ~samp_q[SYNC+1];
      m_fall = ~samp_q[SYNC] & samp_q[SYNC+1];
    end
  endtask

  task automatic compare_all();
    state_e es;
    es = m_run[0] ? MEASURE : (m_lost[0] ? LOST : IDLE);
    check("a.rise", rise_a, m_rise);
    check("a.fall", fall_a, m_fall);
    check("a.period", period_a, m_period[0]);
    check("a.valid", period_valid_a, m_valid[0]);
    check("a.overrun", overrun_a, m_ovr[0]);
    check("a.lost", lost_a, m_lost[0]);
    check("a.state", state_a, es);
    es = m_run[1] ? MEASURE : (m_lost[1] ? LOST : IDLE);
    check("b.rise", rise_b, m_rise);
    check("b.fall", fall_b, m_fall);
    check("b.period", period_b, m_period[1]);
    check("b.valid", period_valid_b, m_valid[1]);
    check("b.overrun", overrun_b, m_ovr[1]);
    check("b.lost", lost_b, m_lost[1]);
    check("b.state", state_b, es);
  endtask

  // ---------------- scoreboard ----------------
  logic [W_A-1:0] exp_qa[$];
  logic [W_B-1:0] exp_qb[$];
  bit sb_on = 0;
  int cur_hi = 0;
  int last_rise_cyc = -1;
  int n_valid_a = 0;
  int last_period_a = 0;
  int n_ovr_a = 0;

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
    if (period_valid_a) begin
      n_valid_a++;
      last_period_a = period_a;
    end
    if (overrun_a) n_ovr_a++;
    if (sb_on) begin
      if (period_valid_a) begin
        check("a.sb_pending", int'(exp_qa.size() > 0), 1);
        if (exp_qa.size() > 0) check("a.sb_period", period_a, exp_qa.pop_front());
      end
      if (period_valid_b) begin
        check("b.sb_pending", int'(exp_qb.size() > 0), 1);
        if (exp_qb.size() > 0) check("b.sb_period", period_b, exp_qb.pop_front());
      end
      if (rise_a) begin
        last_rise_cyc = cyc;
      end else if (fall_a && last_rise_cyc >= 0) begin
        check("a.rise_to_fall", cyc - last_rise_cyc, cur_hi);
        last_rise_cyc = -1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_clk(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      clk_in = 1'b1;
      repeat (hi) tick();
      clk_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic do_reset(input bit ready);
    RESETN = 1'b0;
    clk_in = 1'b0;
    enable = 1'b1;
    period_ready = ready;
    repeat (2) tick();
    RESETN = 1'b1;
  endtask

  task automatic wait_rise_a(input int limit);
    int n;
    n = 0;
    while (!rise_a && n < limit) begin
      tick();
      n++;
    end
    check("a.wait_rise", rise_a, 1);
  endtask

  typedef struct {
    int hi;
    int lo;
    int exp_a;
    int exp_b;  // 0: configuration b produces no measurement
  } row_t;

  row_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    int rem;

    tbl[0] = '{4, 4, 8, 8};
    tbl[1] = '{5, 5, 10, 10};
    tbl[2] = '{2, 3, 5, 5};
    tbl[3] = '{7, 7, 14, 14};
    tbl[4] = '{8, 7, 15, 15};
    tbl[5] = '{8, 8, 16, 0};
    tbl[6] = '{3, 9, 12, 12};
    tbl[7] = '{10, 10, 20, 0};

    // Reset held with clk_in toggling: every output stays low.
    RESETN = 1'b0;
    enable = 1'b1;
    period_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clk_in = ~clk_in;
      tick();
      check("rst.rise_a", rise_a, 0);
      check("rst.fall_a", fall_a, 0);
      check("rst.period_a", period_a, 0);
      check("rst.valid_a", period_valid_a, 0);
      check("rst.overrun_a", overrun_a, 0);
      check("rst.lost_a", lost_a, 0);
      check("rst.period_b", period_b, 0);
      check("rst.valid_b", period_valid_b, 0);
    end

    // Periodic clocks: first rise gives nothing, every later one the period.
    for (int r = 0; r < 8; r++) begin
      do_reset(1'b1);
      for (int k = 0; k < K - 1; k++) begin
        exp_qa.push_back(W_A'(tbl[r].exp_a));
        if (tbl[r].exp_b != 0) exp_qb.push_back(W_B'(tbl[r].exp_b));
      end
      cur_hi = tbl[r].hi;
      last_rise_cyc = -1;
      sb_on = 1;
      drive_clk(tbl[r].hi, tbl[r].lo, K);
      repeat (6) tick();
      sb_on = 0;
      check("a.sb_left", exp_qa.size(), 0);
      check("b.sb_left", exp_qb.size(), 0);
      exp_qa.delete();
      exp_qb.delete();
    end

    // Backpressure: two captures untaken, then ready coincident with a capture.
    do_reset(1'b0);
    n_ovr_a = 0;
    drive_clk(5, 5, 3);
    check("bp.period", period_a, 10);
    check("bp.valid", period_valid_a, 1);
    check("bp.ovr_count", n_ovr_a, 1);
    clk_in = 1'b1;
    wait_rise_a(10);
    period_ready = 1'b1;
    tick();
    check("bp.valid_kept", period_valid_a, 1);
    check("bp.no_overrun", overrun_a, 0);
    check("bp.period2", period_a, 10);
    tick();
    check("bp.drained", period_valid_a, 0);
    clk_in = 1'b0;
    repeat (4) tick();

    // Loss of clock and recovery.
    do_reset(1'b1);
    clk_in = 1'b1;
    wait_rise_a(10);
    n = 0;
    while (!lost_a && n < 100) begin
      if (n == 4) clk_in = 1'b0;
      tick();
      n++;
    end
    check("loss.latency", n, 33);
    n0 = n_valid_a;
    drive_clk(4, 4, 1);
    check("loss.cleared", lost_a, 0);
    check("loss.no_meas", n_valid_a - n0, 0);
    drive_clk(4, 4, 1);
    check("loss.meas_count", n_valid_a - n0, 1);
    check("loss.period", last_period_a, 8);

    // Enable drop with a pending measurement.
    do_reset(1'b0);
    drive_clk(4, 4, 2);
    check("en.valid_before", period_valid_a, 1);
    check("en.state_before", state_a, MEASURE);
    enable = 1'b0;
    tick();
    check("en.valid", period_valid_a, 0);
    check("en.state", state_a, IDLE);
    check("en.lost", lost_a, 0);
    enable = 1'b1;
    period_ready = 1'b1;
    n0 = n_valid_a;
    drive_clk(4, 4, 1);
    check("en.no_meas", n_valid_a - n0, 0);
    drive_clk(4, 4, 1);
    check("en.meas_count", n_valid_a - n0, 1);
    check("en.period", last_period_a, 8);

    // Randomised run against the model.
    do_reset(1'b1);
    rem = 3;
    for (int t = 0; t < 3000; t++) begin
      if (rem == 0) begin
        clk_in = ~clk_in;
        rem = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 45) : $urandom_range(2, 20);
      end
      rem--;
      period_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 49) != 0);
      RESETN = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
